// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The frame is a header word N, then N payload words, then a checksum word.
package imem_boot_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int HDR_BYTES  = 4;
  localparam int CSUM_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs the accepted bytes into little-endian words. word_vld_o pulses in the
// same cycle as the fourth byte's accept, and word_o already includes that byte.
module imem_byte_assembler
  import imem_boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              acc_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]               cnt_q;
  logic [WORD_W-BYTE_W-1:0] sh_q;

  // Only three bytes are stored; the fourth comes straight off the input.
  assign word_vld_o = acc_i && (cnt_q == 2'd3);
  assign word_o     = {byte_i, sh_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (acc_i) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {byte_i, sh_q[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a frame into instruction memory from address 0, checks the additive
// checksum and releases the core's reset only after a good load.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BYTE_W-1:0] s_data,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic              live_q;
  logic [AW:0]       n_q, n_d, idx_q, idx_d;
  logic [WORD_W-1:0] acc_q, acc_d, wdata_q, wdata_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic              accept, word_vld;
  logic [WORD_W-1:0] word;

  assign accept = s_valid && s_ready;

  imem_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      ((state_q == ST_DONE) || (state_q == ST_ERR)),
    .acc_i      (accept),
    .byte_i     (s_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (word_vld) begin
      unique case (state_q)
        ST_HDR: begin
          if (word > WORD_W'(DEPTH)) state_d = ST_ERR;
          else if (word == '0)       state_d = ST_CSUM;
          else                       state_d = ST_LOAD;
        end
        ST_LOAD: if ((idx_q + 1'b1) == n_q) state_d = ST_CSUM;
        ST_CSUM: state_d = (word == acc_q) ? ST_DONE : ST_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // live_q keeps s_ready low until the first edge after reset release.
  always_comb begin
    s_ready   = live_q && ((state_q == ST_HDR) || (state_q == ST_LOAD) ||
                           (state_q == ST_CSUM));
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_ERR);
    cpu_rst_n = (state_q == ST_DONE);
  end

  always_comb begin
    n_d     = n_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (word_vld && (state_q == ST_HDR)) n_d = word[AW:0];
    if (word_vld && (state_q == ST_LOAD)) begin
      we_d    = 1'b1;
      addr_d  = idx_q[AW-1:0];
      wdata_d = word;
      acc_d   = acc_q + word;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized frames for the boot loader, checked against a
// frame-level model: expected writes are (i, payload[i]); success iff sum matches.
module tb_imem_boot_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready, imem_we, cpu_rst_n, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_boot_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t wr_q[$];
  int  tb_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bytes accepted since reset, counted independently of the DUT.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cnt <= 0;
    else if (s_valid && s_ready) tb_cnt <= tb_cnt + 1;

  // A write may only appear once a whole word has arrived.
  always @(negedge clk)
    if (rst_n && imem_we) begin
      wr_t w;
      w.addr = int'(imem_addr);
      w.data = imem_wdata;
      wr_q.push_back(w);
      chk("wr_word_aligned", 64'(tb_cnt % 4), 64'd0);
    end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && t < 20) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_pct);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("rst_outputs", 64'({imem_we, imem_addr, imem_wdata, cpu_rst_n, done, err, s_ready}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_low_after_release", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    chk("rdy_high_first_clk", 64'(s_ready), 64'd1);
    wr_q.delete();
  endtask

  // Model: the frame succeeds iff N <= DEPTH and the checksum equals the
  // 32-bit wrapping sum of the payload; writes go to 0..N-1 in order.
  task automatic run_frame(input string tag, input logic [31:0] hdr,
                           input logic [31:0] words[$], input logic [31:0] csum,
                           input int gap_pct);
    logic [31:0] sum = '0;
    bit exp_ok;
    foreach (words[i]) sum += words[i];
    wr_q.delete();
    send_word(hdr, gap_pct);
    if (hdr > DEPTH) begin
      s_valid = 1'b0;
      chk({tag, "_hdr_err"}, 64'({err, done, cpu_rst_n, s_ready}), 64'b1000);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_hdr_nowr"}, 64'(wr_q.size()), 64'd0);
      return;
    end
    foreach (words[i]) send_word(words[i], gap_pct);
    for (int i = 0; i < 3; i++) send_byte(csum[8*i +: 8], gap_pct);
    chk({tag, "_not_done_early"}, 64'({done, err}), 64'd0);
    send_byte(csum[31:24], gap_pct);
    s_valid = 1'b0;
    exp_ok = (csum == sum);
    chk({tag, "_status"}, 64'({done, err, cpu_rst_n, s_ready}),
        64'({exp_ok, !exp_ok, exp_ok, 1'b0}));
    @(posedge clk); #1;
    chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'(words.size()));
    for (int i = 0; i < words.size() && i < wr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, 64'(wr_q[i].addr), 64'(i));
      chk({tag, "_wr_data"}, 64'(wr_q[i].data), 64'(words[i]));
    end
  endtask

  initial begin
    logic [31:0] ws[$];
    logic [31:0] s;
    do_reset();

    ws = '{32'h00a00093, 32'h01400113};
    run_frame("good2", 32'd2, ws, 32'h01e001a6, 0);
    do_reset();
    run_frame("badsum", 32'd2, ws, 32'h01e001a7, 0);
    do_reset();

    ws.delete();
    run_frame("ovf", 32'(DEPTH + 1), ws, 32'h0, 0);
    do_reset();
    run_frame("empty", 32'd0, ws, 32'h0, 0);
    do_reset();
    run_frame("empty_bad", 32'd0, ws, 32'h1, 0);
    do_reset();

    ws = '{$urandom, $urandom, $urandom};
    s = ws[0] + ws[1] + ws[2];
    run_frame("gaps3", 32'd3, ws, s, 50);
    do_reset();

    // Reset mid-frame: partial word is dropped.
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    ws = '{32'hffb00193};
    run_frame("after_rst", 32'd1, ws, 32'hffb00193, 0);
    do_reset();

    // Reset while the first write strobe is in flight.
    send_word(32'd2, 0);
    send_word(32'hdeadbeef, 0);
    s_valid = 1'b0;
    chk("inflight_we", 64'(imem_we), 64'd1);
    do_reset();

    for (int f = 0; f < 4; f++) begin
      int n = $urandom_range(1, 6);
      ws.delete();
      s = '0;
      for (int i = 0; i < n; i++) begin
        ws.push_back($urandom);
        s += ws[i];
      end
      if ($urandom_range(3) == 0) s ^= 32'(1) << $urandom_range(31);
      run_frame("rand", 32'(n), ws, s, $urandom_range(60));
      do_reset();
    end

    ws.delete();
    s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ws.push_back($urandom);
      s += ws[i];
    end
    run_frame("full", 32'(DEPTH), ws, s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
